// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg
//   Shared definitions for the memory-stage load/store unit: pipeline
//   widths, reset/stall levels, load/store aluop codes and small decode
//   helpers used by mem_lsu and mem_load_align.
package mem_lsu_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        Stop       = 1'b1;
    localparam logic        NoStop     = 1'b0;
    localparam int          RegBus     = 32;
    localparam int          RegAddrBus = 5;
    localparam int          AluOpBus   = 8;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_byte(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP);
    endfunction

    function automatic logic is_half(input logic [7:0] op);
        return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    endfunction

    // Big-endian lane enables: byte address 0 lives in bits [31:24].
    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
        logic [3:0] sel;
        sel = 4'b1111;
        if (is_byte(op)) begin
            case (a)
                2'b00:   sel = 4'b1000;
                2'b01:   sel = 4'b0100;
                2'b10:   sel = 4'b0010;
                default: sel = 4'b0001;
            endcase
        end else if (is_half(op)) begin
            sel = a[1] ? 4'b0011 : 4'b1100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
//   Combinational load-data aligner. Picks the addressed big-endian lane
//   from the raw bus word and sign- or zero-extends it to 32 bits.
//   aluop  - load opcode (LB/LBU/LH/LHU/LW; anything else returns raw)
//   addr   - low two bits of the byte address
//   raw    - captured 32-bit bus word
//   result - aligned, extended load value
module mem_load_align
    import mem_lsu_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop,
    input  logic [1:0]          addr,
    input  logic [RegBus-1:0]   raw,
    output logic [RegBus-1:0]   result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'b00:   byte_lane = raw[31:24];
            2'b01:   byte_lane = raw[23:16];
            2'b10:   byte_lane = raw[15:8];
            default: byte_lane = raw[7:0];
        endcase
        half_lane = addr[1] ? raw[15:0] : raw[31:16];
    end

    always_comb begin
        case (aluop)
            EXE_LB_OP:  result = {{24{byte_lane[7]}}, byte_lane};
            EXE_LBU_OP: result = {24'h0, byte_lane};
            EXE_LH_OP:  result = {{16{half_lane[15]}}, half_lane};
            EXE_LHU_OP: result = {16'h0, half_lane};
            default:    result = raw;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu
//   Memory-stage load/store unit. Turns each load/store arriving from
//   EX/MEM into one req/ack bus transaction, stalls the pipeline until the
//   ack, aligns/extends load data and forwards write-back fields to MEM/WB.
//   Non-memory ops pass straight through combinationally.
//   Optional misaligned-access trap: define MEM_LSU_ALIGN_EXC_EN to add the
//   exc_align_o port and suppress misaligned halfword/word accesses.
// Ports
//   clk, rst           - clock, async active-high reset
//   wd_i..whilo_i      - write-back fields from EX/MEM
//   aluop_i, mem_addr_i, reg2_i - memory op, byte address, store data
//   stall              - pipeline stall vector, bit 4 = MEM stage
//   bus_rdata_i/ack_i  - bus read data and completion
//   wd_o..whilo_o      - write-back fields to MEM/WB
//   stallreq_o         - stall request to pipeline control
//   bus_req_o/we_o/addr_o/sel_o/wdata_o - bus request signals
//   exc_align_o        - misaligned access (macro builds only)
//
// state | meaning
// IDLE  | no access in flight; a new memory op requests a stall
// BUSY  | bus_req_o high, waiting for bus_ack_i
// DONE  | load data captured; hold until MEM stage is released
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic [RegBus-1:0]     hi_i,
    input  logic [RegBus-1:0]     lo_i,
    input  logic                  whilo_i,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [5:0]            stall,
    input  logic [RegBus-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [RegBus-1:0]     bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [RegBus-1:0]     bus_wdata_o
`ifdef MEM_LSU_ALIGN_EXC_EN
    ,
    output logic                  exc_align_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

    state_t             state;
    logic [RegBus-1:0]  rdata_q;
    logic [RegBus-1:0]  ld_data;
    logic               live;
    logic               mem_op;
    logic               misalign;
    logic               exc_align;
    logic               start_ok;
    logic               unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    assign live   = (rst != RstEnable);
    assign mem_op = is_load(aluop_i) || is_store(aluop_i);

`ifdef MEM_LSU_ALIGN_EXC_EN
    assign misalign = (is_half(aluop_i) && mem_addr_i[0]) ||
                      ((aluop_i == EXE_LW_OP || aluop_i == EXE_SW_OP) &&
                       (mem_addr_i[1:0] != 2'b00));
    assign exc_align_o = exc_align;
`else
    // Without the trap, misaligned accesses simply use the aligned lanes.
    assign misalign = 1'b0;
`endif

    assign exc_align = live && (state == IDLE) && mem_op && misalign;
    assign start_ok  = mem_op && !misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state   <= IDLE;
            rdata_q <= ZeroWord;
        end else begin
            case (state)
                IDLE: if (start_ok) state <= BUSY;
                BUSY: begin
                    if (bus_ack_i) begin
                        rdata_q <= bus_rdata_i;
                        state   <= DONE;
                    end
                end
                DONE: if (stall[4] == NoStop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_load_align u_align (
        .aluop  (aluop_i),
        .addr   (mem_addr_i[1:0]),
        .raw    (rdata_q),
        .result (ld_data)
    );

    assign bus_req_o  = live && (state == BUSY);
    assign stallreq_o = live && (((state == IDLE) && start_ok) || (state == BUSY));

    // Bus fields decode straight from EX/MEM, which is frozen while stalled.
    always_comb begin
        bus_we_o    = 1'b0;
        bus_addr_o  = ZeroWord;
        bus_sel_o   = 4'b0000;
        bus_wdata_o = ZeroWord;
        if (bus_req_o) begin
            bus_we_o   = is_store(aluop_i);
            bus_addr_o = {mem_addr_i[31:2], 2'b00};
            bus_sel_o  = lane_sel(aluop_i, mem_addr_i[1:0]);
            case (aluop_i)
                EXE_SB_OP: bus_wdata_o = {4{reg2_i[7:0]}};
                EXE_SH_OP: bus_wdata_o = {2{reg2_i[15:0]}};
                EXE_SW_OP: bus_wdata_o = reg2_i;
                default:   bus_wdata_o = ZeroWord;
            endcase
        end
    end

    always_comb begin
        wd_o    = live ? wd_i : '0;
        wreg_o  = live && wreg_i && !exc_align;
        hi_o    = live ? hi_i : ZeroWord;
        lo_o    = live ? lo_i : ZeroWord;
        whilo_o = live && whilo_i;
        wdata_o = ZeroWord;
        if (live)
            wdata_o = ((state == DONE) && is_load(aluop_i)) ? ld_data : wdata_i;
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_NOP = 8'b0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o;
    logic [31:0] wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o;
    logic        whilo_i, whilo_o;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, bus_rdata_i;
    logic [5:0]  stall;
    logic        bus_ack_i;
    logic        stallreq_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
`ifdef MEM_LSU_ALIGN_EXC_EN
    logic        exc_align_o;
`endif

    int total = 0;
    int bad   = 0;

    int          req_cnt, stall_cnt;
    logic        done_seen;
    logic [3:0]  cap_sel;
    logic [31:0] cap_addr, cap_bwdata, cap_wdata;
    logic        cap_we, cap_wreg;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .stall(stall), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o)
`ifdef MEM_LSU_ALIGN_EXC_EN
        , .exc_align_o(exc_align_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one memory op from IDLE and runs it until DONE; the ack is
    // returned after 'waits' BUSY cycles. Returns with the DUT in DONE.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2, input int waits,
                          input logic [31:0] rdata);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        bus_ack_i  = 1'b0;
        #1;
        req_cnt = 0; stall_cnt = 0; done_seen = 1'b0;
        cap_sel = 4'h0; cap_addr = '0; cap_bwdata = '0; cap_we = 1'b0;
        cap_wdata = '0; cap_wreg = 1'b0;
        for (int c = 0; c < 30 && !done_seen; c++) begin
            if (stallreq_o) stall_cnt++;
            if (bus_req_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_sel = bus_sel_o; cap_addr = bus_addr_o;
                    cap_bwdata = bus_wdata_o; cap_we = bus_we_o;
                end
                bus_ack_i   = (req_cnt > waits);
                bus_rdata_i = bus_ack_i ? rdata : 32'h0;
            end else if (!stallreq_o) begin
                done_seen = 1'b1;
                cap_wdata = wdata_o;
                cap_wreg  = wreg_o;
            end
            if (!done_seen) begin
                step();
                bus_ack_i = 1'b0;
            end
        end
        chk("op_completes", {31'h0, done_seen}, 32'h1);
    endtask

    task automatic finish_op();
        aluop_i = OP_NOP;
        step();
    endtask

    initial begin
        rst = 1'b1;
        wd_i = 5'h1f; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        hi_i = 32'h1111_2222; lo_i = 32'h3333_4444; whilo_i = 1'b1;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; reg2_i = 32'hFFFF_FFFF;
        stall = 6'b0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        step();
        chk("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
        chk("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
        chk("rst_wd", {27'h0, wd_o}, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_whilo", {31'h0, whilo_o}, 32'h0);

        // Non-memory op passes through in the same cycle.
        aluop_i = OP_ADD; wdata_i = 32'd5; wd_i = 5'd3;
        #1 rst = 1'b0;
        #1;
        chk("add_wdata", wdata_o, 32'd5);
        chk("add_wd", {27'h0, wd_o}, 32'd3);
        chk("add_hi", hi_o, 32'h1111_2222);
        chk("add_stallreq", {31'h0, stallreq_o}, 32'h0);
        step();
        chk("add_no_req", {31'h0, bus_req_o}, 32'h0);

        // LW with two wait states.
        run_op(EXE_LW_OP, 32'h100, 32'h0, 2, 32'h1234_5678);
        chk("lw_req_cycles", req_cnt, 32'd3);
        chk("lw_stall_cycles", stall_cnt, 32'd4);
        chk("lw_sel", {28'h0, cap_sel}, 32'hF);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_we", {31'h0, cap_we}, 32'h0);
        chk("lw_wdata", cap_wdata, 32'h1234_5678);
        finish_op();

        // LB, zero-wait, with MEM held in DONE for one extra cycle.
        run_op(EXE_LB_OP, 32'h103, 32'h0, 0, 32'h0000_00F0);
        chk("lb_req_cycles", req_cnt, 32'd1);
        chk("lb_stall_cycles", stall_cnt, 32'd2);
        chk("lb_sel", {28'h0, cap_sel}, 32'h1);
        chk("lb_wdata", cap_wdata, 32'hFFFF_FFF0);
        stall = 6'b01_0000;
        step();
        chk("lb_hold_wdata", wdata_o, 32'hFFFF_FFF0);
        chk("lb_hold_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("lb_hold_req", {31'h0, bus_req_o}, 32'h0);
        stall = 6'b0;
        finish_op();

        run_op(EXE_LBU_OP, 32'h103, 32'h0, 0, 32'h0000_00F0);
        chk("lbu_wdata", cap_wdata, 32'h0000_00F0);
        finish_op();

        run_op(EXE_LH_OP, 32'h102, 32'h0, 1, 32'h1234_8001);
        chk("lh_sel", {28'h0, cap_sel}, 32'h3);
        chk("lh_wdata", cap_wdata, 32'hFFFF_8001);
        finish_op();

        run_op(EXE_LHU_OP, 32'h100, 32'h0, 0, 32'hFFEE_0000);
        chk("lhu_sel", {28'h0, cap_sel}, 32'hC);
        chk("lhu_wdata", cap_wdata, 32'h0000_FFEE);
        finish_op();

        // Stores: write enable, lanes, replication, wdata_o passes wdata_i.
        run_op(EXE_SH_OP, 32'h102, 32'h0000_ABCD, 1, 32'h0);
        chk("sh_we", {31'h0, cap_we}, 32'h1);
        chk("sh_sel", {28'h0, cap_sel}, 32'h3);
        chk("sh_bus_wdata", cap_bwdata, 32'hABCD_ABCD);
        chk("sh_wreg", {31'h0, cap_wreg}, 32'h1);
        chk("sh_wdata", cap_wdata, 32'd5);
        finish_op();

        run_op(EXE_SB_OP, 32'h101, 32'h0000_0012, 0, 32'h0);
        chk("sb_sel", {28'h0, cap_sel}, 32'h4);
        chk("sb_bus_wdata", cap_bwdata, 32'h1212_1212);
        chk("sb_addr", cap_addr, 32'h100);
        finish_op();

        run_op(EXE_SW_OP, 32'h204, 32'h8765_4321, 0, 32'h0);
        chk("sw_sel", {28'h0, cap_sel}, 32'hF);
        chk("sw_bus_wdata", cap_bwdata, 32'h8765_4321);
        finish_op();

`ifdef MEM_LSU_ALIGN_EXC_EN
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h101;
        #1;
        chk("mis_exc", {31'h0, exc_align_o}, 32'h1);
        chk("mis_wreg", {31'h0, wreg_o}, 32'h0);
        chk("mis_stallreq", {31'h0, stallreq_o}, 32'h0);
        step();
        chk("mis_no_req", {31'h0, bus_req_o}, 32'h0);
        chk("mis_exc_hold", {31'h0, exc_align_o}, 32'h1);
        aluop_i = OP_NOP;
        #1;
        chk("mis_exc_clear", {31'h0, exc_align_o}, 32'h0);
`else
        run_op(EXE_LW_OP, 32'h101, 32'h0, 0, 32'hA5A5_5A5A);
        chk("mis_addr", cap_addr, 32'h100);
        chk("mis_sel", {28'h0, cap_sel}, 32'hF);
        chk("mis_wdata", cap_wdata, 32'hA5A5_5A5A);
        finish_op();
`endif

        // Reset in the middle of BUSY; an ack while reset holds is ignored.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h200; wdata_i = 32'd7;
        step();
        chk("mid_busy_req", {31'h0, bus_req_o}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'h0, bus_req_o}, 32'h0);
        chk("mid_rst_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("mid_rst_addr", bus_addr_o, 32'h0);
        chk("mid_rst_wdata", wdata_o, 32'h0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        step();
        bus_ack_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_stallreq", {31'h0, stallreq_o}, 32'h1);
        chk("post_rst_req", {31'h0, bus_req_o}, 32'h0);
        chk("post_rst_wdata", wdata_o, 32'd7);
        aluop_i = OP_NOP;
        step();
        chk("post_rst_idle_req", {31'h0, bus_req_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
